// File: rtl/modport_fifo_pkg.sv
// Shared constants and types for the 128-bit single-clock FIFO.
package modport_fifo_pkg;

    localparam int DATA_WIDTH   = 128;
    localparam int DEPTH        = 16;
    localparam int ALM_FULL_TH  = 12;
    localparam int ALM_EMPTY_TH = 4;
    localparam int ADDR_W       = $clog2(DEPTH);
    localparam int CNT_W        = ADDR_W + 1;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/modport_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and a registered read port.
module modport_fifo_mem #(
    parameter int DATA_WIDTH = modport_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = modport_fifo_pkg::DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    import modport_fifo_pkg::*;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage array write port; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; only the output register is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO: pointers, occupancy count, accept logic and flag decode around the storage array.
module modport_fifo #(
    parameter int DATA_WIDTH   = modport_fifo_pkg::DATA_WIDTH,
    parameter int DEPTH        = modport_fifo_pkg::DEPTH,
    parameter int ALM_FULL_TH  = modport_fifo_pkg::ALM_FULL_TH,
    parameter int ALM_EMPTY_TH = modport_fifo_pkg::ALM_EMPTY_TH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wren,
    input  logic                  i_rden,
    input  logic [DATA_WIDTH-1:0] i_wrdata,
    output logic                  o_full,
    output logic                  o_alm_full,
    output logic                  o_empty,
    output logic                  o_alm_empty,
    output logic [DATA_WIDTH-1:0] o_rddata
);
    import modport_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C      = CW'(DEPTH);
    localparam logic [CW-1:0] ALM_FULL_C  = CW'(ALM_FULL_TH);
    localparam logic [CW-1:0] ALM_EMPTY_C = CW'(ALM_EMPTY_TH);
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE     = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic          full_s;
    logic          alm_full_s;
    logic          empty_s;
    logic          alm_empty_s;

    // Flags decode straight from the registered count so they move with it.
    always_comb begin
        full_s      = 1'b0;
        alm_full_s  = 1'b0;
        empty_s     = 1'b0;
        alm_empty_s = 1'b0;
        if (count_r == FULL_C) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r >= ALM_FULL_C) begin
            alm_full_s = 1'b1;
        end else begin
            alm_full_s = 1'b0;
        end
        if (count_r == {CW{1'b0}}) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        if (count_r <= ALM_EMPTY_C) begin
            alm_empty_s = 1'b1;
        end else begin
            alm_empty_s = 1'b0;
        end
    end

    // Accept qualification: overflow/underflow are dropped and reset wins over both requests.
    always_comb begin
        wr_ok_s = 1'b0;
        rd_ok_s = 1'b0;
        if (reset) begin
            wr_ok_s = 1'b0;
            rd_ok_s = 1'b0;
        end else begin
            wr_ok_s = i_wren & ~full_s;
            rd_ok_s = i_rden & ~empty_s;
        end
    end

    // Pointer registers; wrap at DEPTH falls out of the AW-bit width.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy count; a simultaneous accepted read and write leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    modport_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok_s),
        .waddr (wr_ptr_r),
        .wdata (i_wrdata),
        .re    (rd_ok_s),
        .raddr (rd_ptr_r),
        .rdata (o_rddata)
    );

    assign o_full      = full_s;
    assign o_alm_full  = alm_full_s;
    assign o_empty     = empty_s;
    assign o_alm_empty = alm_empty_s;

endmodule

// File: tb/tb_modport_fifo.sv
// Scoreboard bench for modport_fifo: stimulus queues expected reads, a negedge monitor checks data and flags.
module tb_modport_fifo;
    import modport_fifo_pkg::*;

    logic  clk      = 1'b0;
    logic  reset    = 1'b0;
    logic  i_wren   = 1'b0;
    logic  i_rden   = 1'b0;
    data_t i_wrdata = '0;
    logic  o_full;
    logic  o_alm_full;
    logic  o_empty;
    logic  o_alm_empty;
    data_t o_rddata;

    data_t mq[$];
    data_t exp_q[$];
    logic  rd_acc    = 1'b0;
    logic  mon_valid = 1'b0;
    logic  rst_seen  = 1'b0;
    logic  mon_en    = 1'b0;
    int    exp_cnt   = 0;
    data_t last      = '0;
    int    n_cmp     = 0;
    int    n_err     = 0;

    always #5 clk = ~clk;

    modport_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .i_wrdata    (i_wrdata),
        .o_full      (o_full),
        .o_alm_full  (o_alm_full),
        .o_empty     (o_empty),
        .o_alm_empty (o_alm_empty),
        .o_rddata    (o_rddata)
    );

    task automatic chk(input string name, input data_t act, input data_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Latch what the model expects the DUT to have done at this edge.
    always @(posedge clk) begin
        mon_valid <= rd_acc;
        rst_seen  <= reset;
        exp_cnt   <= reset ? 0 : mq.size();
    end

    // Monitor: pop the expected word when a read was accepted, otherwise expect a hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                last = '0;
            end else if (mon_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_underrun: no expected word queued");
                end else begin
                    last = exp_q.pop_front();
                end
            end
            chk("rddata",    o_rddata,           last);
            chk("full",      data_t'(o_full),      data_t'(exp_cnt == DEPTH));
            chk("alm_full",  data_t'(o_alm_full),  data_t'(exp_cnt >= ALM_FULL_TH));
            chk("empty",     data_t'(o_empty),     data_t'(exp_cnt == 0));
            chk("alm_empty", data_t'(o_alm_empty), data_t'(exp_cnt <= ALM_EMPTY_TH));
        end
    end

    task automatic step(input logic wr, input logic rd, input data_t d);
        logic rdk;
        logic wrk;
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = d;
        rdk = rd && (mq.size() > 0);
        wrk = wr && (mq.size() < DEPTH);
        rd_acc = rdk;
        if (rdk) exp_q.push_back(mq.pop_front());
        if (wrk) mq.push_back(d);
        @(posedge clk);
        @(negedge clk);
        i_wren = 1'b0;
        i_rden = 1'b0;
        rd_acc = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input logic wr, input logic rd);
        reset    = 1'b1;
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = data_t'(32'hBAD0_BAD0);
        rd_acc   = 1'b0;
        mq.delete();
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset  = 1'b0;
        i_wren = 1'b0;
        i_rden = 1'b0;
    endtask

    initial begin
        // Reset and idle state
        do_reset(2, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 1'b0, '0);
        chk("rst_empty",     data_t'(o_empty),     data_t'(1'b1));
        chk("rst_alm_empty", data_t'(o_alm_empty), data_t'(1'b1));
        chk("rst_full",      data_t'(o_full),      data_t'(1'b0));
        chk("rst_alm_full",  data_t'(o_alm_full),  data_t'(1'b0));
        chk("rst_rddata",    o_rddata,             data_t'(0));

        // Fill with 0x1..0x10, checking the flag thresholds by hand
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, data_t'(i));
            if (i == 4)  chk("alm_empty_at4",  data_t'(o_alm_empty), data_t'(1'b1));
            if (i == 5)  chk("alm_empty_at5",  data_t'(o_alm_empty), data_t'(1'b0));
            if (i == 11) chk("alm_full_at11",  data_t'(o_alm_full),  data_t'(1'b0));
            if (i == 12) chk("alm_full_at12",  data_t'(o_alm_full),  data_t'(1'b1));
            if (i == 15) chk("full_at15",      data_t'(o_full),      data_t'(1'b0));
            if (i == 16) chk("full_at16",      data_t'(o_full),      data_t'(1'b1));
        end
        step(1'b1, 1'b0, data_t'(16'hDEAD));

        // Drain 16, then one underflow read
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
        chk("drain_last",  o_rddata,         data_t'(8'h10));
        chk("drain_empty", data_t'(o_empty), data_t'(1'b1));
        step(1'b0, 1'b1, '0);
        chk("underflow_hold", o_rddata, data_t'(8'h10));

        // Simultaneous read+write at count 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, data_t'(8'h21 + i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, data_t'(8'h31 + i));
        chk("simul_alm_empty", data_t'(o_alm_empty), data_t'(1'b0));
        chk("simul_alm_full",  data_t'(o_alm_full),  data_t'(1'b0));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        chk("simul_order_last", o_rddata, data_t'(8'h34));

        // Simultaneous read+write while full: write dropped, count 15
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, data_t'(8'h41 + i));
        step(1'b1, 1'b1, data_t'(16'hBEEF));
        chk("full_rw_full",     data_t'(o_full),     data_t'(1'b0));
        chk("full_rw_alm_full", data_t'(o_alm_full), data_t'(1'b1));
        chk("full_rw_data",     o_rddata,            data_t'(8'h41));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0);
        chk("full_rw_drop", o_rddata, data_t'(8'h50));

        // Simultaneous read+write while empty: write only, no read-through
        step(1'b1, 1'b1, data_t'(8'h77));
        chk("empty_rw_hold",  o_rddata,         data_t'(8'h50));
        chk("empty_rw_empty", data_t'(o_empty), data_t'(1'b0));
        step(1'b0, 1'b1, '0);
        chk("empty_rw_read", o_rddata, data_t'(8'h77));

        // Wrap-around bursts
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) step(1'b1, 1'b0, data_t'(16'h100 + r * 16 + k));
            for (int k = 0; k < 8; k++) step(1'b0, 1'b1, '0);
        end
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, data_t'(16'h200 + k));
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, '0);
        chk("wrap_last", o_rddata, data_t'(16'h209));

        // Mid-operation reset during a write+read cycle
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, data_t'(8'h61 + k));
        do_reset(1, 1'b1, 1'b1);
        chk("midrst_empty",  data_t'(o_empty), data_t'(1'b1));
        chk("midrst_rddata", o_rddata,         data_t'(0));
        step(1'b1, 1'b0, data_t'(8'hA5));
        step(1'b0, 1'b1, '0);
        chk("midrst_a5", o_rddata, data_t'(8'hA5));

        step(1'b0, 1'b0, '0);
        chk("pending_reads", data_t'(exp_q.size()), data_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
